// File: rtl/fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_param_pkg;

   // Default geometry and flag margins
   localparam int DEF_WIDTH     = 32;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AF_MARGIN = 2;
   localparam int DEF_AE_MARGIN = 2;

   // Reset values of the registered status bits
   localparam logic RST_OVF      = 1'b0;
   localparam logic RST_UDF      = 1'b0;
   localparam logic RST_RD_VALID = 1'b0;

   // Ceiling log2 with a floor of 1 bit, so DEPTH=1..2 still gets a real pointer
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param.
// Handshake: a push is taken on a rising edge when pushp & (~fullp | popp);
// a pop is taken when popp & ~emptyp and the head word appears on dop one
// cycle later. clrp flushes and overrides both in the same cycle.
interface fifo_param_if #(
   parameter int WIDTH = fifo_param_pkg::DEF_WIDTH,
   parameter int DEPTH = fifo_param_pkg::DEF_DEPTH
);
   localparam int CW = fifo_param_pkg::clog2(DEPTH + 1);

   logic             clrp;
   logic             pushp;
   logic             popp;
   logic [WIDTH-1:0] dip;
   logic [WIDTH-1:0] dop;
   logic             emptyp;
   logic             fullp;
   logic             lastp;
   logic             afullp;
   logic             aemptyp;
   logic [CW-1:0]    levelp;
   logic             ovfp;
   logic             udfp;

   modport master (
      output clrp, pushp, popp, dip,
      input  dop, emptyp, fullp, lastp, afullp, aemptyp, levelp, ovfp, udfp
   );

   modport slave (
      input  clrp, pushp, popp, dip,
      output dop, emptyp, fullp, lastp, afullp, aemptyp, levelp, ovfp, udfp
   );
endinterface

// File: rtl/fifo_param_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one synchronous read port, no reset.
// A read and a write to the same address on one edge returns the old word.
module fifo_param_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the pushed word and register the read word on the same edge
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: pointers, level counter, flag decode and
// sticky overflow/underflow. Storage lives in fifo_param_ram.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_MARGIN = DEF_AF_MARGIN,
   parameter int AE_MARGIN = DEF_AE_MARGIN
) (
   input  logic        clkp,
   input  logic        rstnp,
   fifo_param_if.slave bus
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] LVL_AF   = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] LVL_AE   = CW'(AE_MARGIN);
   localparam logic [CW-1:0] LVL_ONE  = CW'(1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    level_q;
   logic             ovf_q;
   logic             udf_q;
   logic             rd_valid_q;
   logic             empty;
   logic             full;
   logic             push_ok;
   logic             pop_ok;
   logic [WIDTH-1:0] ram_rdata;

   // Explicit wrap so non-power-of-2 depths work
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + AW'(1);
   endfunction

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);

   // A pop on a full FIFO frees the slot the simultaneous push lands in
   assign push_ok = bus.pushp & (~full | bus.popp) & ~bus.clrp;
   assign pop_ok  = bus.popp & ~empty & ~bus.clrp;

   fifo_param_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clkp),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (bus.dip),
      .re    (pop_ok),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Pointers, level and sticky flags; flush wins over push/pop and leaves dop alone
   always_ff @(posedge clkp or negedge rstnp) begin
      if (!rstnp) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         ovf_q      <= RST_OVF;
         udf_q      <= RST_UDF;
         rd_valid_q <= RST_RD_VALID;
      end else if (bus.clrp) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok) begin
            rd_ptr     <= next_ptr(rd_ptr);
            rd_valid_q <= 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
         if (bus.pushp & full & ~bus.popp) ovf_q <= 1'b1;
         if (bus.popp & empty) udf_q <= 1'b1;
      end
   end

   // The RAM read register has no reset, so dop reads as zero until the first pop
   assign bus.dop     = rd_valid_q ? ram_rdata : '0;
   assign bus.emptyp  = empty;
   assign bus.fullp   = full;
   assign bus.lastp   = (level_q == LVL_ONE);
   assign bus.afullp  = (level_q >= LVL_AF);
   assign bus.aemptyp = (level_q <= LVL_AE);
   assign bus.levelp  = level_q;
   assign bus.ovfp    = ovf_q;
   assign bus.udfp    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a DEPTH=16 instance for fill/drain/flags and a
// DEPTH=5 instance for pointer wrap.
module tb_fifo_param;
   import fifo_param_pkg::*;

   logic clkp  = 1'b0;
   logic rstnp = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] exp_q [$];

   // Clock: 40 ns period
   always #20 clkp = ~clkp;

   fifo_param_if #(.WIDTH(32), .DEPTH(16)) bus  ();
   fifo_param_if #(.WIDTH(32), .DEPTH(5))  bus5 ();

   fifo_param #(.WIDTH(32), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
      .clkp  (clkp),
      .rstnp (rstnp),
      .bus   (bus)
   );

   fifo_param #(.WIDTH(32), .DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2)) dut5 (
      .clkp  (clkp),
      .rstnp (rstnp),
      .bus   (bus5)
   );

   task automatic tick();
      @(posedge clkp);
      #1;
   endtask

   task automatic drive(input logic push, input logic pop, input logic [31:0] d);
      bus.pushp = push;
      bus.popp  = pop;
      bus.dip   = d;
      tick();
      bus.pushp = 1'b0;
      bus.popp  = 1'b0;
   endtask

   task automatic test_reset();
      bus.clrp = 0; bus.pushp = 0; bus.popp = 0; bus.dip = '0;
      bus5.clrp = 0; bus5.pushp = 0; bus5.popp = 0; bus5.dip = '0;
      rstnp = 1'b0;
      tick(); tick();
      total++; if (bus.levelp !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.levelp); end
      total++; if (bus.emptyp !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.emptyp); end
      total++; if (bus.aemptyp !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b want=1", bus.aemptyp); end
      total++; if ({bus.fullp, bus.lastp, bus.afullp} !== 3'b000) begin bad++; $display("FAIL reset_full_last_af got=%b want=000", {bus.fullp, bus.lastp, bus.afullp}); end
      total++; if (bus.dop !== 32'h0) begin bad++; $display("FAIL reset_dop got=%h want=00000000", bus.dop); end
      total++; if ({bus.ovfp, bus.udfp} !== 2'b00) begin bad++; $display("FAIL reset_ovf_udf got=%b want=00", {bus.ovfp, bus.udfp}); end
      total++; if (bus5.emptyp !== 1'b1) begin bad++; $display("FAIL reset_empty5 got=%b want=1", bus5.emptyp); end
      rstnp = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      logic [7:0]  b;
      logic [31:0] d;
      for (int k = 1; k <= 16; k++) begin
         b = 8'(k * 17);
         d = (k == 16) ? 32'h0 : {b, 16'h0000, b};
         exp_q.push_back(d);
         drive(1'b1, 1'b0, d);
         total++; if (bus.levelp !== 5'(k)) begin bad++; $display("FAIL fill_level k=%0d got=%0d want=%0d", k, bus.levelp, k); end
         total++; if (bus.emptyp !== 1'b0) begin bad++; $display("FAIL fill_empty k=%0d got=%b want=0", k, bus.emptyp); end
         total++; if (bus.lastp !== (k == 1)) begin bad++; $display("FAIL fill_last k=%0d got=%b want=%b", k, bus.lastp, (k == 1)); end
         total++; if (bus.afullp !== (k >= 14)) begin bad++; $display("FAIL fill_afull k=%0d got=%b want=%b", k, bus.afullp, (k >= 14)); end
         total++; if (bus.fullp !== (k == 16)) begin bad++; $display("FAIL fill_full k=%0d got=%b want=%b", k, bus.fullp, (k == 16)); end
         total++; if (bus.aemptyp !== (k <= 2)) begin bad++; $display("FAIL fill_aempty k=%0d got=%b want=%b", k, bus.aemptyp, (k <= 2)); end
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 1'b0, 32'hDEADBEEF);
      total++; if (bus.ovfp !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus.ovfp); end
      total++; if (bus.levelp !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d want=16", bus.levelp); end
      total++; if (bus.fullp !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", bus.fullp); end
   endtask

   task automatic test_drain();
      logic [31:0] e;
      for (int k = 16; k >= 1; k--) begin
         if (k == 1) begin
            total++; if (bus.lastp !== 1'b1) begin bad++; $display("FAIL drain_last_before got=%b want=1", bus.lastp); end
         end
         drive(1'b0, 1'b1, 32'h0);
         e = exp_q.pop_front();
         total++; if (bus.dop !== e) begin bad++; $display("FAIL drain_dop k=%0d got=%h want=%h", k, bus.dop, e); end
         total++; if (bus.levelp !== 5'(k - 1)) begin bad++; $display("FAIL drain_level got=%0d want=%0d", bus.levelp, k - 1); end
      end
      total++; if (bus.emptyp !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", bus.emptyp); end
      total++; if (bus.udfp !== 1'b0) begin bad++; $display("FAIL drain_udf_early got=%b want=0", bus.udfp); end
      drive(1'b0, 1'b1, 32'h0);
      total++; if (bus.udfp !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b want=1", bus.udfp); end
      total++; if (bus.dop !== 32'h0) begin bad++; $display("FAIL udf_dop_hold got=%h want=00000000", bus.dop); end
      total++; if (bus.ovfp !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.ovfp); end
   endtask

   task automatic test_full_rw();
      logic [31:0] e;
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(32'h1000_0000 + 32'(k));
         drive(1'b1, 1'b0, 32'h1000_0000 + 32'(k));
      end
      drive(1'b1, 1'b1, 32'hA5A5A5A5);
      e = exp_q.pop_front();
      exp_q.push_back(32'hA5A5A5A5);
      total++; if (bus.dop !== e) begin bad++; $display("FAIL fullrw_dop got=%h want=%h", bus.dop, e); end
      total++; if (bus.levelp !== 5'd16) begin bad++; $display("FAIL fullrw_level got=%0d want=16", bus.levelp); end
      total++; if (bus.fullp !== 1'b1) begin bad++; $display("FAIL fullrw_full got=%b want=1", bus.fullp); end
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 1'b1, 32'h0);
         e = exp_q.pop_front();
         total++; if (bus.dop !== e) begin bad++; $display("FAIL fullrw_drain k=%0d got=%h want=%h", k, bus.dop, e); end
      end
   endtask

   task automatic test_wrap();
      int          ops [24];
      logic [31:0] q5 [$];
      logic [31:0] d, e;
      logic        push, pop, pok, wok;
      ops = '{2, 2, 2, 3, 1, 2, 2, 2, 3, 3, 1, 1, 2, 2, 3, 1, 1, 1, 2, 3, 3, 1, 1, 1};
      e = '0;
      for (int i = 0; i < 24; i++) begin
         push = ops[i][1];
         pop  = ops[i][0];
         d    = 32'h5000_0000 + 32'(i);
         pok  = pop && (q5.size() > 0);
         wok  = push && ((q5.size() < 5) || pop);
         bus5.pushp = push; bus5.popp = pop; bus5.dip = d;
         tick();
         bus5.pushp = 1'b0; bus5.popp = 1'b0;
         if (pok) e = q5.pop_front();
         if (wok) q5.push_back(d);
         total++; if (bus5.levelp !== 3'(q5.size())) begin bad++; $display("FAIL wrap_level i=%0d got=%0d want=%0d", i, bus5.levelp, q5.size()); end
         if (pok) begin
            total++; if (bus5.dop !== e) begin bad++; $display("FAIL wrap_dop i=%0d got=%h want=%h", i, bus5.dop, e); end
         end
      end
   endtask

   task automatic test_clear();
      for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 32'h70 + 32'(k));
      total++; if (bus.levelp !== 5'd7) begin bad++; $display("FAIL clr_pre_level got=%0d want=7", bus.levelp); end
      bus.clrp = 1'b1;
      drive(1'b1, 1'b1, 32'hFFFF0000);
      bus.clrp = 1'b0;
      total++; if (bus.levelp !== 5'd0) begin bad++; $display("FAIL clr_level got=%0d want=0", bus.levelp); end
      total++; if (bus.emptyp !== 1'b1) begin bad++; $display("FAIL clr_empty got=%b want=1", bus.emptyp); end
      total++; if ({bus.ovfp, bus.udfp} !== 2'b00) begin bad++; $display("FAIL clr_ovf_udf got=%b want=00", {bus.ovfp, bus.udfp}); end
      total++; if (bus.dop !== 32'hA5A5A5A5) begin bad++; $display("FAIL clr_dop_hold got=%h want=a5a5a5a5", bus.dop); end
      drive(1'b1, 1'b0, 32'hC0DE0001);
      total++; if (bus.levelp !== 5'd1) begin bad++; $display("FAIL clr_push_level got=%0d want=1", bus.levelp); end
      drive(1'b0, 1'b1, 32'h0);
      total++; if (bus.dop !== 32'hC0DE0001) begin bad++; $display("FAIL clr_new_data got=%h want=c0de0001", bus.dop); end
      total++; if (bus.emptyp !== 1'b1) begin bad++; $display("FAIL clr_new_empty got=%b want=1", bus.emptyp); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 32'hB0 + 32'(k));
      #5 rstnp = 1'b0;
      #2;
      total++; if (bus.levelp !== 5'd0) begin bad++; $display("FAIL rst_mid_level got=%0d want=0", bus.levelp); end
      total++; if (bus.emptyp !== 1'b1) begin bad++; $display("FAIL rst_mid_empty got=%b want=1", bus.emptyp); end
      total++; if (bus.dop !== 32'h0) begin bad++; $display("FAIL rst_mid_dop got=%h want=00000000", bus.dop); end
      #10 rstnp = 1'b1;
      drive(1'b1, 1'b0, 32'hBEEF0002);
      drive(1'b1, 1'b0, 32'hBEEF0003);
      drive(1'b0, 1'b1, 32'h0);
      total++; if (bus.dop !== 32'hBEEF0002) begin bad++; $display("FAIL rst_mid_first got=%h want=beef0002", bus.dop); end
      total++; if (bus.levelp !== 5'd1) begin bad++; $display("FAIL rst_mid_level1 got=%0d want=1", bus.levelp); end
      drive(1'b0, 1'b1, 32'h0);
      total++; if (bus.dop !== 32'hBEEF0003) begin bad++; $display("FAIL rst_mid_second got=%h want=beef0003", bus.dop); end
      total++; if (bus.emptyp !== 1'b1) begin bad++; $display("FAIL rst_mid_empty_end got=%b want=1", bus.emptyp); end
   endtask

   // Run scenarios in order, then report
   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_full_rw();
      test_wrap();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
